// File: rtl/eth_tx_frame_builder.sv
// eth_tx_frame_builder: turns a header command plus a payload byte stream
// into a single 8-bit AXI-Stream Ethernet frame (header + payload). The
// downstream MAC adds padding and the FCS. A payload whose length does not
// match the command ends with tuser=1 so that the TX frame FIFO drops it.
module eth_tx_frame_builder #(
  parameter int MAX_PAYLOAD = 1500,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [47:0]          cmd_dst_mac,
  input  logic [47:0]          cmd_src_mac,
  input  logic [15:0]          cmd_ethertype,
  input  logic [15:0]          cmd_len,
  input  logic [7:0]           s_payload_tdata,
  input  logic                 s_payload_tvalid,
  output logic                 s_payload_tready,
  input  logic                 s_payload_tlast,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 busy,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 err_oversize,
  output logic [CNT_WIDTH-1:0] frames_sent
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_t;

  state_t      state;
  logic [47:0] dst_r;
  logic [47:0] src_r;
  logic [15:0] type_r;
  logic [15:0] len_r;
  logic [3:0]  hdr_cnt;
  logic [15:0] pay_cnt;
  logic [7:0]  hdr_byte;
  logic        adv;
  logic        pay_hs;

  // Output register may load when it is empty or its byte is being taken
  assign adv       = !m_axis_tvalid || m_axis_tready;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign pay_hs    = s_payload_tvalid && s_payload_tready;

  // Payload is only pulled when it can be forwarded, or when discarding
  always_comb begin
    s_payload_tready = 1'b0;
    if (state == PAY)        s_payload_tready = adv;
    else if (state == DRAIN) s_payload_tready = 1'b1;
  end

  // Header byte select: dst MAC, src MAC, EtherType, most significant first
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_cnt)
      4'd0:    hdr_byte = dst_r[47:40];
      4'd1:    hdr_byte = dst_r[39:32];
      4'd2:    hdr_byte = dst_r[31:24];
      4'd3:    hdr_byte = dst_r[23:16];
      4'd4:    hdr_byte = dst_r[15:8];
      4'd5:    hdr_byte = dst_r[7:0];
      4'd6:    hdr_byte = src_r[47:40];
      4'd7:    hdr_byte = src_r[39:32];
      4'd8:    hdr_byte = src_r[31:24];
      4'd9:    hdr_byte = src_r[23:16];
      4'd10:   hdr_byte = src_r[15:8];
      4'd11:   hdr_byte = src_r[7:0];
      4'd12:   hdr_byte = type_r[15:8];
      4'd13:   hdr_byte = type_r[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Frame FSM, output register, error pulses and good-frame counter
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state         <= IDLE;
      dst_r         <= '0;
      src_r         <= '0;
      type_r        <= '0;
      len_r         <= '0;
      hdr_cnt       <= '0;
      pay_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      err_oversize  <= 1'b0;
      frames_sent   <= '0;
    end else begin
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_oversize <= 1'b0;
      // Byte consumed (or register empty): drop valid unless reloaded below
      if (adv) m_axis_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dst_r  <= cmd_dst_mac;
            src_r  <= cmd_src_mac;
            type_r <= cmd_ethertype;
            len_r  <= cmd_len;
            if (cmd_len > 16'(MAX_PAYLOAD)) begin
              // Oversize: emit nothing, just swallow the payload
              err_oversize <= 1'b1;
              state        <= DRAIN;
            end else begin
              hdr_cnt <= '0;
              state   <= HDR;
            end
          end
        end

        HDR: begin
          if (adv) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hdr_byte;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            hdr_cnt       <= hdr_cnt + 4'd1;
            if (hdr_cnt == 4'd13) begin
              if (len_r == '0) begin
                m_axis_tlast <= 1'b1;
                frames_sent  <= frames_sent + CNT_WIDTH'(1);
                state        <= IDLE;
              end else begin
                pay_cnt <= len_r;
                state   <= PAY;
              end
            end
          end
        end

        PAY: begin
          if (pay_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_payload_tdata;
            if (pay_cnt == 16'd1) begin
              m_axis_tlast <= 1'b1;
              if (s_payload_tlast) begin
                m_axis_tuser <= 1'b0;
                frames_sent  <= frames_sent + CNT_WIDTH'(1);
                state        <= IDLE;
              end else begin
                // Source still has bytes: mark bad and discard the rest
                m_axis_tuser <= 1'b1;
                err_long     <= 1'b1;
                state        <= DRAIN;
              end
            end else if (s_payload_tlast) begin
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= 1'b1;
              err_short    <= 1'b1;
              state        <= IDLE;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= 1'b0;
              pay_cnt      <= pay_cnt - 16'd1;
            end
          end
        end

        DRAIN: begin
          if (pay_hs && s_payload_tlast) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_builder.sv
// Scoreboard bench for eth_tx_frame_builder: the stimulus side pushes the
// expected frame bytes computed from the frame rules; a monitor pops and
// compares every accepted output byte and checks hold-while-stalled.
module tb_eth_tx_frame_builder;
  localparam int MAXP = 1500;

  logic        logic_clk = 1'b0;
  logic        logic_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] cmd_dst_mac;
  logic [47:0] cmd_src_mac;
  logic [15:0] cmd_ethertype;
  logic [15:0] cmd_len;
  logic [7:0]  s_payload_tdata;
  logic        s_payload_tvalid;
  logic        s_payload_tready;
  logic        s_payload_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;
  logic        err_short;
  logic        err_long;
  logic        err_oversize;
  logic [15:0] frames_sent;

  eth_tx_frame_builder #(.MAX_PAYLOAD(MAXP), .CNT_WIDTH(16)) dut (
    .logic_clk(logic_clk), .logic_rst(logic_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst_mac(cmd_dst_mac), .cmd_src_mac(cmd_src_mac),
    .cmd_ethertype(cmd_ethertype), .cmd_len(cmd_len),
    .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid),
    .s_payload_tready(s_payload_tready), .s_payload_tlast(s_payload_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .busy(busy),
    .err_short(err_short), .err_long(err_long), .err_oversize(err_oversize),
    .frames_sent(frames_sent)
  );

  always #5 logic_clk = ~logic_clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t exp_q[$];
  int tests = 0, fails = 0;
  int exp_frames = 0, exp_short = 0, exp_long = 0, exp_over = 0;
  int got_short = 0, got_long = 0, got_over = 0, got_bytes = 0;
  bit bp_en = 1'b0;
  bit abort = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always 1, or a 50% coin when backpressure is enabled
  always @(posedge logic_clk) begin
    #1 m_axis_tready = bp_en ? 1'($urandom % 2) : 1'b1;
  end

  // Monitor: compare accepted bytes, hold-while-stalled, count pulses
  beat_t mon_e;
  bit    stall = 1'b0;
  beat_t prev;
  always @(negedge logic_clk) begin
    if (logic_rst) begin
      stall = 1'b0;
    end else begin
      if (stall)
        chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
            {1'b1, prev.d, prev.l, prev.u});
      if (m_axis_tvalid && m_axis_tready) begin
        got_bytes++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_byte: got %0h with nothing expected", m_axis_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat{data,last,user}", {m_axis_tdata, m_axis_tlast, m_axis_tuser},
              {mon_e.d, mon_e.l, mon_e.u});
        end
      end
      got_short += int'(err_short);
      got_long  += int'(err_long);
      got_over  += int'(err_oversize);
      stall = m_axis_tvalid && !m_axis_tready;
      prev  = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser};
    end
  end

  // Reference: expected output of one frame from the frame rules
  task automatic model(input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] et, input int len, input int n,
                       input logic [7:0] pay[$]);
    logic [111:0] hdr;
    int nout;
    bit bad;
    if (len > MAXP) begin
      exp_over++;
      return;
    end
    hdr  = {dst, src, et};
    nout = (n < len) ? n : len;
    bad  = (n != len);
    for (int i = 0; i < 14; i++)
      exp_q.push_back('{d: hdr[111-8*i -: 8], l: (i == 13 && len == 0), u: 1'b0});
    for (int i = 0; i < nout; i++)
      exp_q.push_back('{d: pay[i], l: (i == nout-1), u: (i == nout-1) && bad});
    if (!bad) exp_frames++;
    else if (n < len) exp_short++;
    else exp_long++;
  endtask

  // Issue one command and feed n payload bytes (tlast on the n-th)
  task automatic run_frame(input int len, input int n);
    logic [7:0]  pay[$];
    logic [47:0] dst, src;
    logic [15:0] et;
    int t;
    dst = {$urandom, $urandom};
    src = {$urandom, $urandom};
    et  = 16'($urandom);
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    model(dst, src, et, len, n, pay);
    cmd_dst_mac = dst; cmd_src_mac = src; cmd_ethertype = et; cmd_len = 16'(len);
    cmd_valid = 1'b1;
    @(negedge logic_clk);
    t = 0;
    while (!cmd_ready && t < 3000) begin @(negedge logic_clk); t++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL cmd_timeout: cmd_ready 0, expected 1");
    end
    @(posedge logic_clk); #1;
    cmd_valid = 1'b0;
    cmd_dst_mac = {$urandom, $urandom}; cmd_src_mac = {$urandom, $urandom};
    cmd_ethertype = 16'($urandom); cmd_len = 16'($urandom);
    @(negedge logic_clk);
    chk("busy_after_cmd", busy, 1'b1);
    @(posedge logic_clk); #1;
    for (int i = 0; i < n && !abort; i++) begin
      if ($urandom % 4 == 0) begin
        s_payload_tvalid = 1'b0;
        @(posedge logic_clk); #1;
      end
      s_payload_tdata  = pay[i];
      s_payload_tlast  = (i == n-1);
      s_payload_tvalid = 1'b1;
      @(negedge logic_clk);
      t = 0;
      while (!s_payload_tready && !abort && t < 3000) begin @(negedge logic_clk); t++; end
      if (!s_payload_tready && !abort) begin
        tests++; fails++;
        $display("FAIL payload_timeout: s_payload_tready 0, expected 1");
        break;
      end
      @(posedge logic_clk); #1;
    end
    s_payload_tvalid = 1'b0;
    s_payload_tlast  = 1'b0;
    if (n > 0 && !abort) begin
      @(negedge logic_clk);
      chk("cmd_ready_after_tlast", cmd_ready, 1'b1);
      @(posedge logic_clk); #1;
    end
  endtask

  // Wait for the scoreboard to drain, then compare counters and pulses
  task automatic settle(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin @(negedge logic_clk); t++; end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s drain_timeout: %0d bytes missing, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge logic_clk);
    chk({tag, " frames_sent"}, frames_sent, exp_frames);
    chk({tag, " err_short"}, got_short, exp_short);
    chk({tag, " err_long"}, got_long, exp_long);
    chk({tag, " err_oversize"}, got_over, exp_over);
    @(posedge logic_clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, " tlast/tuser"}, {m_axis_tlast, m_axis_tuser}, 2'b00);
    chk({tag, " tdata"}, m_axis_tdata, 8'h00);
    chk({tag, " cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, " s_tready"}, s_payload_tready, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " errs"}, {err_short, err_long, err_oversize}, 3'b000);
    chk({tag, " frames_sent"}, frames_sent, 16'd0);
  endtask

  initial begin
    int base, t, len, n, mode;
    logic_rst = 1'b1; cmd_valid = 1'b0; cmd_dst_mac = '0; cmd_src_mac = '0;
    cmd_ethertype = '0; cmd_len = '0; s_payload_tdata = '0;
    s_payload_tvalid = 1'b0; s_payload_tlast = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(posedge logic_clk);
    #1 logic_rst = 1'b0;
    @(negedge logic_clk);
    chk_reset_vals("reset");
    @(posedge logic_clk); #1;

    // Directed cases
    run_frame(46, 46);   settle("normal46");
    run_frame(10, 4);    settle("short");
    run_frame(4, 8);     settle("long");
    run_frame(0, 0);     settle("len0");
    run_frame(1501, 5);  settle("oversize");
    bp_en = 1'b1;
    run_frame(100, 100); settle("backpressure");
    bp_en = 1'b0;

    // Reset at output byte 30 of a frame, then a fresh frame
    base = got_bytes;
    fork
      run_frame(46, 46);
      begin
        t = 0;
        while (got_bytes - base < 30 && t < 2000) begin @(negedge logic_clk); t++; end
        @(posedge logic_clk); #1;
        logic_rst = 1'b1; abort = 1'b1;
        @(posedge logic_clk); #1;
        logic_rst = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        @(negedge logic_clk);
        chk_reset_vals("midreset");
      end
    join
    abort = 1'b0;
    @(posedge logic_clk); #1;
    run_frame(46, 46); settle("after_reset");

    // Randomized mix
    for (int k = 0; k < 30; k++) begin
      bp_en = 1'($urandom % 2);
      mode  = int'($urandom % 8);
      case (mode)
        0: begin len = 1501 + int'($urandom % 100); n = 1 + int'($urandom % 5); end
        1: begin len = 0; n = 0; end
        2, 3: begin len = 2 + int'($urandom % 39); n = 1 + int'($urandom % (len - 1)); end
        4: begin len = 1 + int'($urandom % 30); n = len + 1 + int'($urandom % 6); end
        default: begin len = 1 + int'($urandom % 40); n = len; end
      endcase
      run_frame(len, n);
    end
    settle("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
